// File: rtl/mem_responder_pkg.sv
// mem_resp_types: shared FSM state encoding and counter width for mem_responder
package mem_resp_types;
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_resp_state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: memory bus (read/write/byte_enable/address/wdata from initiator; rdata/resp/addr_err/proto_err from responder)
interface mem_responder_if;
  logic mem_read;
  logic mem_write;
  logic [3:0] mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic mem_resp;
  logic addr_err;
  logic proto_err;
  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input mem_rdata, mem_resp, addr_err, proto_err
  );
  modport slave (
    input mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp, addr_err, proto_err
  );
endinterface

// File: rtl/mem_responder_sram_1rw.sv
// sram_1rw: 2^AW x 32 single-port array; ports clk, we/be/wdata byte-masked write, re registered read into q, shared addr
module sram_1rw #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   q
);
  logic [31:0] mem [0:2**AW-1];
  always_ff @(posedge clk) begin
    if (re) q <= mem[addr];
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency single-request memory responder; ports clk, rst (sync active-high), bus (mem_responder_if.slave)
module mem_responder
  import mem_resp_types::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY = 3
) (
  input logic clk,
  input logic rst,
  mem_responder_if.slave bus
);
  mem_resp_state_t state, state_n;
  cnt_t cnt;
  logic op_rd, oor_q, zero_q, addr_err_q, proto_err_q;
  logic [3:0] be_q;
  logic [ADDR_WIDTH-1:0] idx_q, addr;
  logic [31:0] wdata_q, q;
  logic req, oor, issue, rd_now, oor_now, we, re, unused_addr;
  assign req = bus.mem_read | bus.mem_write;
  assign oor = |bus.mem_address[31:ADDR_WIDTH+2];
  assign unused_addr = &{1'b0, bus.mem_address[1:0]};
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb
    state_n = (state == IDLE) ? (req ? (LATENCY > 1 ? BUSY : RESP) : IDLE)
            : (state == BUSY) ? (cnt == cnt_t'(1) ? RESP : BUSY)
            : IDLE;
  // The array read is launched on the edge that enters RESP so the registered data lands with mem_resp
  always_comb begin
    issue   = (state == IDLE && req && LATENCY == 1) || (state == BUSY && cnt == cnt_t'(1));
    rd_now  = (state == IDLE) ? bus.mem_read : op_rd;
    oor_now = (state == IDLE) ? oor : oor_q;
    addr    = (state == IDLE) ? bus.mem_address[ADDR_WIDTH+1:2] : idx_q;
    re      = issue && rd_now;
    we      = (state == RESP) && !op_rd && !oor_q && !rst;
    bus.mem_resp  = (state == RESP);
    bus.mem_rdata = zero_q ? 32'h0 : q;
    bus.addr_err  = addr_err_q;
    bus.proto_err = proto_err_q;
  end
  // zero_q masks the array output after reset and for out-of-range reads, and only changes when a read is launched
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      zero_q      <= 1'b1;
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        op_rd       <= bus.mem_read;
        oor_q       <= oor;
        idx_q       <= bus.mem_address[ADDR_WIDTH+1:2];
        be_q        <= bus.mem_byte_enable;
        wdata_q     <= bus.mem_wdata;
        cnt         <= cnt_t'(LATENCY - 1);
        addr_err_q  <= addr_err_q | oor;
        proto_err_q <= proto_err_q | (bus.mem_read & bus.mem_write);
      end else if (state == BUSY) begin
        cnt <= cnt - cnt_t'(1);
      end
      if (re) zero_q <= oor_now;
    end
  end
  sram_1rw #(.AW(ADDR_WIDTH)) u_sram (
    .clk(clk),
    .we(we),
    .re(re),
    .be(be_q),
    .addr(addr),
    .wdata(wdata_q),
    .q(q)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder at LATENCY=3 and LATENCY=1
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mem_responder_if b3();
  mem_responder_if b1();
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  typedef struct {
    int cyc;
    logic chk;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] model [0:1023];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (b3.mem_resp) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected cyc=%0d", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.cyc) begin
          fails++;
          $display("FAIL resp_cycle got=%0d want=%0d", cyc, mon_e.cyc);
        end
        if (mon_e.chk) begin
          tests++;
          if (b3.mem_rdata !== mon_e.data) begin
            fails++;
            $display("FAIL rdata got=%h want=%h", b3.mem_rdata, mon_e.data);
          end
        end
      end
    end
  end
  task automatic clear3();
    b3.mem_read = 0; b3.mem_write = 0; b3.mem_byte_enable = 0; b3.mem_address = 0; b3.mem_wdata = 0;
  endtask
  task automatic wait_resp3(input string name);
    int n = 0;
    @(negedge clk);
    while (!b3.mem_resp && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!b3.mem_resp) begin
      fails++;
      $display("FAIL %s timeout got=resp0 want=resp1", name);
    end
  endtask
  task automatic check_drained(input string name);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s pending got=%0d want=0", name, sb.size());
      sb.delete();
    end
  endtask
  task automatic req3(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input string name);
    exp_t e;
    int w;
    logic o;
    @(posedge clk); #1;
    b3.mem_read = rd; b3.mem_write = wr; b3.mem_address = a; b3.mem_wdata = wd; b3.mem_byte_enable = be;
    w = int'(a[11:2]);
    o = |a[31:12];
    e.cyc = cyc + 3;
    e.chk = rd;
    e.data = o ? 32'h0 : model[w];
    if (!rd && wr && !o)
      for (int i = 0; i < 4; i++) if (be[i]) model[w][8*i +: 8] = wd[8*i +: 8];
    sb.push_back(e);
    wait_resp3(name);
    @(posedge clk); #1;
    clear3();
    check_drained(name);
  endtask
  task automatic test_reset();
    rst = 1;
    clear3();
    b1.mem_read = 0; b1.mem_write = 0; b1.mem_byte_enable = 0; b1.mem_address = 0; b1.mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    tests += 4;
    if (b3.mem_resp !== 1'b0) begin fails++; $display("FAIL reset_resp got=%b want=0", b3.mem_resp); end
    if (b3.mem_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h want=0", b3.mem_rdata); end
    if (b3.addr_err !== 1'b0) begin fails++; $display("FAIL reset_addr_err got=%b want=0", b3.addr_err); end
    if (b3.proto_err !== 1'b0) begin fails++; $display("FAIL reset_proto_err got=%b want=0", b3.proto_err); end
  endtask
  task automatic test_write_read();
    req3(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_10");
    req3(1, 0, 32'h10, 0, 4'h0, "rd_10");
    tests++;
    if (b3.mem_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_10_hold got=%h want=deadbeef", b3.mem_rdata); end
    req3(0, 1, 32'h0, 32'hA0A0A0A0, 4'hF, "wr_0");
    req3(0, 1, 32'h4, 32'hB1B1B1B1, 4'hF, "wr_4");
    req3(0, 1, 32'h8, 32'hC2C2C2C2, 4'hF, "wr_8");
    tests++;
    if (b3.mem_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rdata_hold_writes got=%h want=deadbeef", b3.mem_rdata); end
  endtask
  task automatic test_byte_lanes();
    req3(0, 1, 32'h10, 32'h11223344, 4'b0101, "wr_be5");
    req3(1, 0, 32'h10, 0, 4'h0, "rd_be5");
    tests++;
    if (b3.mem_rdata !== 32'hDE22BE44) begin fails++; $display("FAIL be5_value got=%h want=de22be44", b3.mem_rdata); end
    req3(0, 1, 32'h10, 32'h55667788, 4'b0000, "wr_be0");
    req3(1, 0, 32'h10, 0, 4'h0, "rd_be0");
    tests++;
    if (b3.mem_rdata !== 32'hDE22BE44) begin fails++; $display("FAIL be0_value got=%h want=de22be44", b3.mem_rdata); end
  endtask
  task automatic test_back_to_back();
    exp_t e;
    @(posedge clk); #1;
    b3.mem_read = 1; b3.mem_address = 32'h0;
    for (int k = 0; k < 3; k++) begin
      e.cyc = cyc + 3 + 4 * k;
      e.chk = 1;
      e.data = model[k];
      sb.push_back(e);
    end
    for (int k = 0; k < 3; k++) begin
      wait_resp3("b2b");
      b3.mem_address = 32'(4 * (k + 1));
    end
    @(posedge clk); #1;
    clear3();
    check_drained("b2b");
  endtask
  task automatic test_addr_err();
    req3(0, 1, 32'h1000, 32'hCAFEF00D, 4'hF, "wr_oor");
    tests++;
    if (b3.addr_err !== 1'b1) begin fails++; $display("FAIL addr_err_set got=%b want=1", b3.addr_err); end
    req3(1, 0, 32'h0, 0, 4'h0, "rd_alias");
    tests++;
    if (b3.mem_rdata !== 32'hA0A0A0A0) begin fails++; $display("FAIL no_alias got=%h want=a0a0a0a0", b3.mem_rdata); end
    req3(1, 0, 32'h1000, 0, 4'h0, "rd_oor");
    tests += 2;
    if (b3.mem_rdata !== 32'h0) begin fails++; $display("FAIL oor_rdata got=%h want=0", b3.mem_rdata); end
    if (b3.addr_err !== 1'b1) begin fails++; $display("FAIL addr_err_sticky got=%b want=1", b3.addr_err); end
  endtask
  task automatic test_proto();
    tests++;
    if (b3.proto_err !== 1'b0) begin fails++; $display("FAIL proto_pre got=%b want=0", b3.proto_err); end
    req3(1, 1, 32'h10, 32'hFFFFFFFF, 4'hF, "rdwr");
    tests++;
    if (b3.proto_err !== 1'b1) begin fails++; $display("FAIL proto_err got=%b want=1", b3.proto_err); end
    req3(1, 0, 32'h10, 0, 4'h0, "rd_after_rdwr");
    tests++;
    if (b3.mem_rdata !== 32'hDE22BE44) begin fails++; $display("FAIL rdwr_no_write got=%h want=de22be44", b3.mem_rdata); end
  endtask
  task automatic test_reset_mid();
    @(posedge clk); #1;
    b3.mem_write = 1; b3.mem_address = 32'h10; b3.mem_wdata = 32'h0BADF00D; b3.mem_byte_enable = 4'hF;
    @(posedge clk); #1;
    rst = 1;
    clear3();
    @(posedge clk); #1;
    rst = 0;
    tests += 4;
    if (b3.mem_resp !== 1'b0) begin fails++; $display("FAIL midrst_resp got=%b want=0", b3.mem_resp); end
    if (b3.mem_rdata !== 32'h0) begin fails++; $display("FAIL midrst_rdata got=%h want=0", b3.mem_rdata); end
    if (b3.addr_err !== 1'b0) begin fails++; $display("FAIL midrst_addr_err got=%b want=0", b3.addr_err); end
    if (b3.proto_err !== 1'b0) begin fails++; $display("FAIL midrst_proto_err got=%b want=0", b3.proto_err); end
    repeat (5) @(posedge clk);
    req3(1, 0, 32'h10, 0, 4'h0, "rd_after_midrst");
  endtask
  task automatic test_latency1();
    @(posedge clk); #1;
    b1.mem_write = 1; b1.mem_address = 32'h20; b1.mem_wdata = 32'h12345678; b1.mem_byte_enable = 4'hF;
    @(negedge clk);
    tests++;
    if (b1.mem_resp !== 1'b0) begin fails++; $display("FAIL l1_wr_early got=%b want=0", b1.mem_resp); end
    @(negedge clk);
    tests++;
    if (b1.mem_resp !== 1'b1) begin fails++; $display("FAIL l1_wr_resp got=%b want=1", b1.mem_resp); end
    @(posedge clk); #1;
    b1.mem_write = 0; b1.mem_read = 1;
    @(negedge clk);
    tests++;
    if (b1.mem_resp !== 1'b0) begin fails++; $display("FAIL l1_rd_early got=%b want=0", b1.mem_resp); end
    @(negedge clk);
    tests += 2;
    if (b1.mem_resp !== 1'b1) begin fails++; $display("FAIL l1_rd_resp got=%b want=1", b1.mem_resp); end
    if (b1.mem_rdata !== 32'h12345678) begin fails++; $display("FAIL l1_rdata got=%h want=12345678", b1.mem_rdata); end
    @(posedge clk); #1;
    b1.mem_read = 0;
    @(negedge clk);
    tests++;
    if (b1.mem_resp !== 1'b0) begin fails++; $display("FAIL l1_resp_width got=%b want=0", b1.mem_resp); end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_addr_err();
    test_proto();
    test_reset_mid();
    test_latency1();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end
endmodule
